riscv_run_controller: RTL
=========================

// Module: riscv_run_controller
// PURPOSE
//  Parametrised run/reset sequencer for the single-cycle RISC-V core: replaces fixed-delay reset and run windows.
//  Holds the core in reset for a programmable number of cycles, then releases it on a start request.
//  Counts cycles and retired instructions, and detects program end: ECALL/EBREAK, or a PC self-loop.
//  Reports done/pass/timeout with the captured exit code; sits between the top-level clock/reset and RISC_V_Processor.
// PARAMETERS
//  XLEN          32    width of pc and exit_code
//  CNT_W         32    width of cycle_count / instret_count (saturating)
//  RESET_CYCLES  2     cycles core_reset is held high after start (>=1)
//  MAX_CYCLES    1000  RUN cycles before timeout (>=1, < 2**CNT_W)
//  LOOP_CYCLES   4     consecutive retires at an identical pc that count as a self-loop halt (>=2)
//  HALT_ON_ECALL 1     1: ECALL (0x00000073) / EBREAK (0x00100073) retire ends the run; 0: ignored
// PORTS
//  clk           in   1      system clock, rising edge
//  reset         in   1      asynchronous, active-low controller reset
//  start         in   1      1-cycle run request; honoured in IDLE and DONE only
//  retire        in   1      core retired an instruction this cycle
//  pc            in   XLEN   pc of the retiring instruction (valid with retire)
//  instr         in   32     encoding of the retiring instruction (valid with retire)
//  exit_code     in   XLEN   core register x10 (a0), sampled at halt
//  core_reset    out  1      active-high reset to the processor (registered)
//  running       out  1      1 in RUN
//  done          out  1      1 in DONE
//  pass          out  1      DONE by halt with exit code 0
//  timeout       out  1      DONE by MAX_CYCLES expiry
//  cycle_count   out  CNT_W  RUN cycles elapsed
//  instret_count out  CNT_W  retires counted in RUN
//  exit_code_q   out  XLEN   exit_code captured at halt; 0 on timeout
// BEHAVIOUR
//  - reset low (async): state=IDLE; core_reset=1; all other outputs 0; hold/loop counters 0; last_pc=0.
//  - States: IDLE -> RESET_HOLD -> RUN -> DONE; DONE -> RESET_HOLD on start.
//  - IDLE: core_reset=1. start=1 -> RESET_HOLD next cycle.
//  - RESET_HOLD:
//      * Entry clears cycle_count, instret_count, pass, timeout, exit_code_q and the loop counter.
//      * core_reset=1 for exactly RESET_CYCLES clock cycles, then RUN; core_reset is 0 from the first RUN cycle.
//  - RUN:
//      * cycle_count increments every cycle; instret_count increments on each retire.
//      * Both counters saturate at 2**CNT_W-1.
//      * ECALL/EBREAK retire with HALT_ON_ECALL=1 -> halt.
//      * Loop detect:
//          - retire with pc==last_pc: loop counter +1.
//          - retire with a different pc: loop counter =1.
//          - last_pc updates on every retire.
//          - loop counter reaching LOOP_CYCLES -> halt.
//      * Halt: capture exit_code into exit_code_q; pass=(exit_code==0); next state DONE.
//      * The cycle on which cycle_count==MAX_CYCLES-1 without halt: timeout=1, exit_code_q=0, next state DONE.
//      * Halt and timeout in the same cycle: halt wins, timeout=0.
//      * Non-retire cycles leave the loop counter unchanged.
//      * start is ignored in RUN.
//  - DONE:
//      * core_reset=1 on the cycle after halt/timeout; done=1.
//      * pass, timeout, counters and exit_code_q are frozen.
//      * start -> RESET_HOLD; that entry clears done and the other flags.
//  - Latency:
//      * start to core_reset falling = RESET_CYCLES+1 cycles.
//      * halt retire to done rising = 1 cycle.
//  - reset asserted mid-run: immediate return to IDLE with core_reset=1; no flags retained.
//  - Outputs are all registered; no combinational path from inputs to outputs.
// TESTING
//  1. reset low 2 cycles, start pulse -> core_reset high 3 cycles (RESET_CYCLES=2 +1), then running=1, cycle_count counts 1,2,3.
//  2. RUN, retire ECALL at pc=0x40 with exit_code=0 after 10 retires -> next cycle done=1, pass=1, instret_count=11, exit_code_q=0.
//  3. retire "jal x0,0" at pc=0x20 each cycle with exit_code=5 -> 4th retire halts; done=1, pass=0, exit_code_q=5.
//  4. MAX_CYCLES=16, no retires -> timeout=1 after cycle_count=15, exit_code_q=0; ECALL on that same cycle -> pass path, timeout=0.
//  5. In DONE, start pulse -> done=0, counters 0, core_reset held 2 cycles, second run behaves as scenario 2.
//  6. reset pulled low in RUN at cycle 7 -> core_reset=1 asynchronously, all outputs 0; start ignored while reset low.

Source files
------------

// File: rtl/riscv_run_controller.sv
// rtl/riscv_run_controller.sv - run/reset sequencer for the single-cycle RISC-V core
//
// Holds the core in reset for RESET_CYCLES after a start request, runs it,
// counts cycles and retired instructions, and stops on ECALL/EBREAK, a pc
// self-loop, or MAX_CYCLES expiry. All outputs come from registers.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-low controller reset
//   start         in   run request, honoured in IDLE and DONE
//   retire        in   core retired an instruction this cycle
//   pc            in   pc of the retiring instruction
//   instr         in   encoding of the retiring instruction
//   exit_code     in   core register a0, sampled at halt
//   core_reset    out  active-high reset to the processor
//   running       out  controller is in RUN
//   done          out  controller is in DONE
//   pass          out  halted with exit code 0
//   timeout       out  stopped by MAX_CYCLES expiry
//   cycle_count   out  RUN cycles elapsed (saturating)
//   instret_count out  retires counted in RUN (saturating)
//   exit_code_q   out  exit code captured at halt, 0 on timeout

module riscv_run_controller #(
  parameter int XLEN          = 32,
  parameter int CNT_W         = 32,
  parameter int RESET_CYCLES  = 2,
  parameter int MAX_CYCLES    = 1000,
  parameter int LOOP_CYCLES   = 4,
  parameter int HALT_ON_ECALL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              retire,
  input  logic [XLEN-1:0]   pc,
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   exit_code,
  output logic              core_reset,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instret_count,
  output logic [XLEN-1:0]   exit_code_q
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int LOOP_W = $clog2(LOOP_CYCLES + 1);

  localparam logic [31:0]      INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0]      INSTR_EBREAK = 32'h0010_0073;
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CYC_LAST     = CNT_W'(MAX_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [LOOP_W-1:0] LOOP_HALT   = LOOP_W'(LOOP_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               core_reset_q, core_reset_d;
  logic               pass_q, pass_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]   instret_count_q, instret_count_d;
  logic [XLEN-1:0]    exit_capture_q, exit_capture_d;
  logic [XLEN-1:0]    last_pc_q, last_pc_d;
  logic [LOOP_W-1:0]  loop_cnt_q, loop_cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               is_system;
  logic               halt;
  logic               clear_run;

  always_comb begin
    state_d         = state_q;
    core_reset_d    = core_reset_q;
    pass_d          = pass_q;
    timeout_d       = timeout_q;
    cycle_count_d   = cycle_count_q;
    instret_count_d = instret_count_q;
    exit_capture_d  = exit_capture_q;
    last_pc_d       = last_pc_q;
    loop_cnt_d      = loop_cnt_q;
    hold_d          = hold_q;
    halt            = 1'b0;
    clear_run       = 1'b0;
    is_system       = (HALT_ON_ECALL != 0) &&
                      ((instr == INSTR_ECALL) || (instr == INSTR_EBREAK));

    case (state_q)
      S_IDLE: begin
        core_reset_d = 1'b1;
        if (start) begin
          state_d   = S_RESET_HOLD;
          clear_run = 1'b1;
        end
      end

      S_RESET_HOLD: begin
        // hold_q counts the RESET_HOLD cycles already spent; release on the last one
        if (hold_q == HOLD_LAST) begin
          state_d      = S_RUN;
          core_reset_d = 1'b0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      S_RUN: begin
        if (cycle_count_q != CNT_MAX) cycle_count_d = cycle_count_q + 1'b1;
        if (retire) begin
          if (instret_count_q != CNT_MAX) instret_count_d = instret_count_q + 1'b1;
          last_pc_d  = pc;
          loop_cnt_d = (pc == last_pc_q) ? loop_cnt_q + 1'b1 : LOOP_W'(1);
        end
        halt = retire && (is_system || (loop_cnt_d == LOOP_HALT));
        // halt takes priority over a timeout landing on the same cycle
        if (halt) begin
          exit_capture_d = exit_code;
          pass_d         = (exit_code == '0);
          timeout_d      = 1'b0;
          state_d        = S_DONE;
          core_reset_d   = 1'b1;
        end else if (cycle_count_q == CYC_LAST) begin
          exit_capture_d = '0;
          timeout_d      = 1'b1;
          state_d        = S_DONE;
          core_reset_d   = 1'b1;
        end
      end

      S_DONE: begin
        core_reset_d = 1'b1;
        if (start) begin
          state_d   = S_RESET_HOLD;
          clear_run = 1'b1;
        end
      end

      default: begin
        state_d      = S_IDLE;
        core_reset_d = 1'b1;
      end
    endcase

    if (clear_run) begin
      cycle_count_d   = '0;
      instret_count_d = '0;
      pass_d          = 1'b0;
      timeout_d       = 1'b0;
      exit_capture_d  = '0;
      loop_cnt_d      = '0;
      hold_d          = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      core_reset_q    <= 1'b1;
      pass_q          <= 1'b0;
      timeout_q       <= 1'b0;
      cycle_count_q   <= '0;
      instret_count_q <= '0;
      exit_capture_q  <= '0;
      last_pc_q       <= '0;
      loop_cnt_q      <= '0;
      hold_q          <= '0;
    end else begin
      state_q         <= state_d;
      core_reset_q    <= core_reset_d;
      pass_q          <= pass_d;
      timeout_q       <= timeout_d;
      cycle_count_q   <= cycle_count_d;
      instret_count_q <= instret_count_d;
      exit_capture_q  <= exit_capture_d;
      last_pc_q       <= last_pc_d;
      loop_cnt_q      <= loop_cnt_d;
      hold_q          <= hold_d;
    end
  end

  assign core_reset    = core_reset_q;
  assign running       = (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign cycle_count   = cycle_count_q;
  assign instret_count = instret_count_q;
  assign exit_code_q   = exit_capture_q;

endmodule
